// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - length-prefixed byte-stream loader that packs words into the instruction ROM
// Optional feature macro: LOADER_CHECKSUM_EN (adds a trailing XOR checksum byte and the CSUM state)
module rom_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              reload,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [31:0]       rom_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [23:0]       asm_q, asm_d;
    logic              rx_ready_q, rx_ready_d;
    logic              rom_we_q, rom_we_d;
    logic [ADDR_W-1:0] rom_waddr_q, rom_waddr_d;
    logic [31:0]       rom_wdata_q, rom_wdata_d;
    logic              core_hold_q, core_hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
    localparam state_t S_AFTER_IMAGE = S_CSUM;
`else
    localparam state_t S_AFTER_IMAGE = S_DONE;
`endif

    logic        xfer;
    logic [15:0] len_full;
    logic        len_too_big;
    logic        last_word;

    assign xfer        = rx_valid & rx_ready_q;
    assign len_full    = {rx_data, len_q[7:0]};
    // 17-bit compare so a full 2**ADDR_W-word image is still accepted
    assign len_too_big = 17'(len_full) > (17'd1 << ADDR_W);
    assign last_word   = 17'(word_idx_q) == (17'(len_q) - 17'd1);

    // Next-state logic: reload wins over any byte offered in the same cycle
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        byte_idx_d  = byte_idx_q;
        asm_d       = asm_q;
        rom_we_d    = 1'b0;
        rom_waddr_d = rom_waddr_q;
        rom_wdata_d = rom_wdata_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        if (reload) begin
            state_d    = S_LEN0;
            word_idx_d = '0;
            byte_idx_d = '0;
`ifdef LOADER_CHECKSUM_EN
            csum_d     = '0;
`endif
        end else if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
            if (state_q != S_CSUM) begin
                csum_d = csum_q ^ rx_data;
            end
`endif
            case (state_q)
                S_LEN0: begin
                    len_d[7:0] = rx_data;
                    state_d    = S_LEN1;
                end
                S_LEN1: begin
                    len_d[15:8] = rx_data;
                    word_idx_d  = '0;
                    byte_idx_d  = '0;
                    if (len_too_big) begin
                        state_d = S_ERROR;
                    end else if (len_full == 16'd0) begin
                        state_d = S_AFTER_IMAGE;
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0: asm_d[7:0]   = rx_data;
                        2'd1: asm_d[15:8]  = rx_data;
                        2'd2: asm_d[23:16] = rx_data;
                        default: begin
                            rom_we_d    = 1'b1;
                            rom_waddr_d = word_idx_q;
                            rom_wdata_d = {rx_data, asm_q};
                            word_idx_d  = word_idx_q + 1'b1;
                            if (last_word) begin
                                state_d = S_AFTER_IMAGE;
                            end
                        end
                    endcase
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: begin
                    state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
                end
`endif
                default: ;
            endcase
        end
        // Status outputs follow the state being entered so they change on the same edge
        rx_ready_d  = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                      (state_d == S_DATA) || (state_d == S_CSUM);
        done_d      = (state_d == S_DONE);
        core_hold_d = (state_d != S_DONE);
        error_d     = (state_d == S_ERROR);
    end

    // State and registered outputs; reset returns everything to the idle LEN0 values
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_LEN0;
            len_q       <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            asm_q       <= '0;
            rx_ready_q  <= 1'b0;
            rom_we_q    <= 1'b0;
            rom_waddr_q <= '0;
            rom_wdata_q <= '0;
            core_hold_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            byte_idx_q  <= byte_idx_d;
            asm_q       <= asm_d;
            rx_ready_q  <= rx_ready_d;
            rom_we_q    <= rom_we_d;
            rom_waddr_q <= rom_waddr_d;
            rom_wdata_q <= rom_wdata_d;
            core_hold_q <= core_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign rx_ready  = rx_ready_q;
    assign rom_we    = rom_we_q;
    assign rom_waddr = rom_waddr_q;
    assign rom_wdata = rom_wdata_q;
    assign core_hold = core_hold_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - scoreboard bench for rom_loader (LOADER_CHECKSUM_EN aware)
module tb_rom_loader;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              reload;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_waddr;
    logic [31:0]       rom_wdata;
    logic              core_hold;
    logic              done;
    logic              error;

    int checks = 0;
    int errors = 0;

    logic [40:0] exp_q[$];
    logic [40:0] obs_q[$];
    logic [7:0]  img[$];
    int          we_long = 0;
    logic        prev_we = 1'b0;

    rom_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .reload(reload), .rom_we(rom_we),
        .rom_waddr(rom_waddr), .rom_wdata(rom_wdata), .core_hold(core_hold),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Capture every ROM write with the done flag seen alongside it
    always @(negedge clk) begin
        if (rom_we) begin
            obs_q.push_back({done, rom_waddr, rom_wdata});
            if (prev_we) we_long++;
        end
        prev_we = rom_we;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_w(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic last);
`ifdef LOADER_CHECKSUM_EN
        exp_q.push_back({1'b0, a, d});
`else
        exp_q.push_back({last, a, d});
`endif
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("rx_ready_timeout", {63'd0, rx_ready}, 64'd1);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic send_img(input int gap, input logic add_csum);
        logic [7:0] x = 8'h00;
        foreach (img[i]) begin
            send(img[i]);
            x ^= img[i];
            if (gap > 0) idle(gap);
        end
`ifdef LOADER_CHECKSUM_EN
        if (add_csum) send(x);
`else
        if (add_csum) x = 8'h00;
`endif
        idle(4);
    endtask

    task automatic drain(input string tag);
        logic [40:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) check({tag, "_missing"}, 64'(obs_q.size()), 64'd1);
            else check(tag, 64'(obs_q.pop_front()), 64'(e));
        end
        check({tag, "_extra"}, 64'(obs_q.size()), 64'd0);
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rx_ready"}, {63'd0, rx_ready}, 64'd0);
        check({tag, "_rom_we"}, {63'd0, rom_we}, 64'd0);
        check({tag, "_waddr"}, 64'(rom_waddr), 64'd0);
        check({tag, "_wdata"}, 64'(rom_wdata), 64'd0);
        check({tag, "_core_hold"}, {63'd0, core_hold}, 64'd1);
        check({tag, "_done"}, {63'd0, done}, 64'd0);
        check({tag, "_error"}, {63'd0, error}, 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; reload = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b1;
        @(negedge clk);
        check("rdy_after_rst", {63'd0, rx_ready}, 64'd1);

        // Two-word image back-to-back
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        push_w(8'd0, 32'h00000513, 1'b0);
        push_w(8'd1, 32'h00100593, 1'b1);
        send_img(0, 1'b1);
        drain("t1_write");
        check("t1_done", {63'd0, done}, 64'd1);
        check("t1_hold", {63'd0, core_hold}, 64'd0);
        check("t1_rdy", {63'd0, rx_ready}, 64'd0);
        check("t1_waddr_hold", 64'(rom_waddr), 64'd1);
        check("t1_wdata_hold", 64'(rom_wdata), 64'h00100593);

        pulse_reload();
        check("rl_done", {63'd0, done}, 64'd0);
        check("rl_hold", {63'd0, core_hold}, 64'd1);
        check("rl_rdy", {63'd0, rx_ready}, 64'd1);

        // Same image with 3 idle cycles between bytes
        push_w(8'd0, 32'h00000513, 1'b0);
        push_w(8'd1, 32'h00100593, 1'b1);
        send_img(3, 1'b1);
        drain("t2_write");
        check("t2_done", {63'd0, done}, 64'd1);
        check("t2_we_width", 64'(we_long), 64'd0);

        // Oversize length 257
        pulse_reload();
        img = '{8'h01, 8'h01};
        send_img(0, 1'b0);
        check("t3_error", {63'd0, error}, 64'd1);
        check("t3_rdy", {63'd0, rx_ready}, 64'd0);
        check("t3_hold", {63'd0, core_hold}, 64'd1);
        check("t3_done", {63'd0, done}, 64'd0);
        drain("t3_nowrite");
        pulse_reload();
        check("t3_rl_error", {63'd0, error}, 64'd0);
        check("t3_rl_rdy", {63'd0, rx_ready}, 64'd1);

        // Partial word then reload coinciding with a valid byte (byte dropped)
        img = '{8'h01, 8'h00, 8'h13, 8'h05};
        send_img(0, 1'b0);
        @(negedge clk);
        rx_data = 8'h77; rx_valid = 1'b1; reload = 1'b1;
        @(negedge clk);
        reload = 1'b0; rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        drain("t4_nowrite");
        img = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        push_w(8'd0, 32'hDDCCBBAA, 1'b1);
        send_img(0, 1'b1);
        drain("t4_write");
        check("t4_done", {63'd0, done}, 64'd1);

        // Full-capacity image: 256 words, last address 255
        pulse_reload();
        img = '{8'h00, 8'h01};
        for (int w = 0; w < 256; w++) begin
            for (int k = 0; k < 4; k++) img.push_back(8'((4 * w + k) & 8'hFF));
            push_w(8'(w), {8'((4 * w + 3) & 8'hFF), 8'((4 * w + 2) & 8'hFF),
                           8'((4 * w + 1) & 8'hFF), 8'((4 * w) & 8'hFF)}, (w == 255));
        end
        send_img(0, 1'b1);
        drain("tmax_write");
        check("tmax_done", {63'd0, done}, 64'd1);
        check("tmax_err", {63'd0, error}, 64'd0);

        // Zero-length image
        pulse_reload();
        img = '{8'h00, 8'h00};
        send_img(0, 1'b1);
        check("t5_done", {63'd0, done}, 64'd1);
        check("t5_hold", {63'd0, core_hold}, 64'd0);
        drain("t5_nowrite");

`ifdef LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        pulse_reload();
        img = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        push_w(8'd0, 32'h44332211, 1'b1);
        send_img(0, 1'b0);
        drain("t6_write");
        check("t6_done", {63'd0, done}, 64'd1);
        pulse_reload();
        img = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h46};
        push_w(8'd0, 32'h44332211, 1'b1);
        send_img(0, 1'b0);
        drain("t6b_write");
        check("t6b_error", {63'd0, error}, 64'd1);
        check("t6b_done", {63'd0, done}, 64'd0);
`endif

        // Reset in the middle of a load
        pulse_reload();
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00};
        push_w(8'd0, 32'h00000513, 1'b0);
        foreach (img[i]) send(img[i]);
        @(negedge clk);
        rx_valid = 1'b0;
        #2 reset = 1'b0;
        #1 check_reset_vals("midrst");
        drain("midrst_write");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_rdy", {63'd0, rx_ready}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
